// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: STAGES valid/ready slots carrying a data and a control bundle,
// with global stall (en_i), synchronous flush and bubble collapse toward the output end.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4,
  parameter int STAGES = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DATA_W-1:0]            data_i,
  input  logic [CTRL_W-1:0]            ctrl_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DATA_W-1:0]            data_o,
  output logic [CTRL_W-1:0]            ctrl_o,
  output logic [$clog2(STAGES+1)-1:0]  occ_o
);

  localparam int OCC_W = $clog2(STAGES + 1);

  if (STAGES < 1) begin : g_bad_stages
    $error("pipe_stage_reg: STAGES must be >= 1");
  end

  logic [STAGES-1:0] v_q, v_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [CTRL_W-1:0] ctrl_q [STAGES];
  logic [CTRL_W-1:0] ctrl_d [STAGES];
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [STAGES-1:0] adv;

  function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int k = 0; k < STAGES; k++) n = n + OCC_W'(v[k]);
    return n;
  endfunction

  // A slot may advance when any slot at or beyond it is empty, or the output is draining.
  always_comb begin
    logic hole;
    hole = out_ready_i;
    adv  = '0;
    if (en_i && !flush_i) begin
      for (int k = STAGES - 1; k >= 0; k--) begin
        hole   = hole | ~v_q[k];
        adv[k] = hole;
      end
    end
  end

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (flush_i) begin
      v_d = '0;
      for (int k = 0; k < STAGES; k++) ctrl_d[k] = '0;
    end else begin
      if (adv[0]) begin
        v_d[0] = in_valid_i;
        if (in_valid_i) begin
          data_d[0] = data_i;
          ctrl_d[0] = ctrl_i;
        end else begin
          ctrl_d[0] = '0;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) begin
            data_d[k] = data_q[k-1];
            ctrl_d[k] = ctrl_q[k-1];
          end else begin
            ctrl_d[k] = '0;
          end
        end
      end
    end
    occ_d = popcount(v_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        ctrl_q[k] <= '0;
      end
    end else begin
      v_q    <= v_d;
      occ_q  <= occ_d;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  // Control of an empty slot is always zero, so the last slot drives ctrl_o directly.
  assign in_ready_o  = adv[0];
  assign out_valid_o = v_q[STAGES-1];
  assign data_o      = data_q[STAGES-1];
  assign ctrl_o      = ctrl_q[STAGES-1];
  assign occ_o       = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg (STAGES=3) against a slot-shift model
// plus an in-order scoreboard of accepted entries.
module tb_pipe_stage_reg;
  localparam int S  = 3;
  localparam int DW = 64;
  localparam int CW = 4;
  localparam int OW = $clog2(S + 1);

  logic          clk;
  logic          rst, en, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] data_in, data_out;
  logic [CW-1:0] ctrl_in, ctrl_out;
  logic [OW-1:0] occ;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STAGES(S)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_i(data_in), .ctrl_i(ctrl_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .data_o(data_out), .ctrl_o(ctrl_out), .occ_o(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  int tests = 0;
  int fails = 0;
  bit model_ok = 0;
  bit            mv [S];
  logic [DW-1:0] md [S];
  logic [CW-1:0] mc [S];
  ent_t          q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int mcount();
    int n = 0;
    for (int k = 0; k < S; k++) if (mv[k]) n++;
    return n;
  endfunction

  // Model: if the output slot drains or is empty the whole pipe shifts by one; otherwise
  // only the part up to the highest empty slot shifts, the packed tail holds.
  task automatic model_edge();
    int h;
    bit ir;
    ent_t e;
    if (rst) begin
      for (int k = 0; k < S; k++) begin mv[k] = 0; md[k] = '0; mc[k] = '0; end
      q.delete();
      model_ok = 1;
      return;
    end
    if (!model_ok) return;
    if (flush) begin
      for (int k = 0; k < S; k++) begin mv[k] = 0; mc[k] = '0; end
      q.delete();
      return;
    end
    if (!en) return;
    ir = (mcount() < S) || out_ready;
    if (mv[S-1] && out_ready && q.size() > 0) void'(q.pop_front());
    if (in_valid && ir) begin
      e.d = data_in; e.c = ctrl_in;
      q.push_back(e);
    end
    if (!mv[S-1] || out_ready) h = S - 1;
    else begin
      h = -1;
      for (int k = S - 1; k >= 0; k--) if (h < 0 && !mv[k]) h = k;
    end
    for (int k = h; k >= 1; k--) begin
      if (mv[k-1]) begin md[k] = md[k-1]; mc[k] = mc[k-1]; end
      else mc[k] = '0;
      mv[k] = mv[k-1];
    end
    if (h >= 0) begin
      if (in_valid) begin md[0] = data_in; mc[0] = ctrl_in; end
      else mc[0] = '0;
      mv[0] = in_valid;
    end
  endtask

  task automatic compare();
    bit exp_ir;
    if (!model_ok) return;
    exp_ir = en && !flush && ((mcount() < S) || out_ready);
    chk("out_valid", 64'(out_valid), 64'(mv[S-1]));
    chk("data_o", data_out, md[S-1]);
    chk("ctrl_o", 64'(ctrl_out), 64'(mc[S-1]));
    chk("occ_o", 64'(occ), 64'(mcount()));
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    if (out_valid && out_ready && en && !flush && !rst) begin
      chk("sb_depth", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        chk("sb_data", data_out, q[0].d);
        chk("sb_ctrl", 64'(ctrl_out), 64'(q[0].c));
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare();
  endtask

  task automatic edge_();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick();
    settle();
    edge_();
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v; data_in = d; ctrl_in = c;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; en = 1; flush = 0; out_ready = 0;
    drive(1, 64'hAA, 4'hF);
    // Reset with a valid input offered
    tick();
    settle();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_data", data_out, 64'd0);
    chk("rst_ctrl", 64'(ctrl_out), 64'd0);
    edge_();
    rst = 0;
    drive(0, 64'h0, 4'h0);
    settle();
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_occ", 64'(occ), 64'd0);
    edge_();

    // Streaming
    out_ready = 1;
    drive(1, 64'h10, 4'b0011); tick();
    drive(1, 64'h11, 4'b0011); tick();
    drive(1, 64'h12, 4'b0011); tick();
    drive(0, 64'h0, 4'h0);
    settle(); chk("str_v0", 64'(out_valid), 64'd1); chk("str_d0", data_out, 64'h10);
    chk("str_c0", 64'(ctrl_out), 64'h3); edge_();
    settle(); chk("str_d1", data_out, 64'h11); edge_();
    settle(); chk("str_d2", data_out, 64'h12); edge_();
    settle(); chk("str_end_v", 64'(out_valid), 64'd0); chk("str_end_c", 64'(ctrl_out), 64'd0); edge_();

    // Backpressure with a bubble that must collapse
    out_ready = 0;
    drive(1, 64'hA0, 4'h1); tick();
    drive(0, 64'h0, 4'h0); tick();
    drive(1, 64'hB0, 4'h2); tick();
    drive(1, 64'hC0, 4'h5); tick();
    drive(0, 64'h0, 4'h0);
    settle(); chk("bp_occ", 64'(occ), 64'd3); chk("bp_ready", 64'(in_ready), 64'd0);
    chk("bp_head", data_out, 64'hA0); edge_();
    out_ready = 1;
    settle(); chk("bp_a", data_out, 64'hA0); edge_();
    settle(); chk("bp_b_v", 64'(out_valid), 64'd1); chk("bp_b", data_out, 64'hB0); edge_();
    settle(); chk("bp_c_v", 64'(out_valid), 64'd1); chk("bp_c", data_out, 64'hC0); edge_();
    settle(); chk("bp_empty", 64'(out_valid), 64'd0); edge_();

    // Flush a full pipe while D is offered
    out_ready = 0;
    drive(1, 64'hD1, 4'h1); tick();
    drive(1, 64'hD2, 4'h2); tick();
    drive(1, 64'hD3, 4'h3); tick();
    flush = 1; drive(1, 64'hDD, 4'hF);
    settle(); chk("fl_ready", 64'(in_ready), 64'd0); edge_();
    flush = 0; drive(0, 64'h0, 4'h0);
    settle(); chk("fl_valid", 64'(out_valid), 64'd0); chk("fl_occ", 64'(occ), 64'd0);
    chk("fl_ctrl", 64'(ctrl_out), 64'd0); edge_();
    out_ready = 1;
    repeat (4) tick();

    // Stall with input offered and downstream ready
    out_ready = 0;
    drive(1, 64'hE1, 4'h1); tick();
    drive(1, 64'hE2, 4'h2); tick();
    drive(1, 64'hE3, 4'h3); tick();
    en = 0; out_ready = 1; drive(1, 64'hEE, 4'hE);
    repeat (4) begin
      settle(); chk("st_ready", 64'(in_ready), 64'd0); chk("st_data", data_out, 64'hE1);
      chk("st_occ", 64'(occ), 64'd3); edge_();
    end
    en = 1; drive(0, 64'h0, 4'h0);
    settle(); chk("st_e1", data_out, 64'hE1); edge_();
    settle(); chk("st_e2", data_out, 64'hE2); edge_();
    settle(); chk("st_e3", data_out, 64'hE3); edge_();
    tick();

    // Reset and flush together, then an input under stall
    out_ready = 0;
    drive(1, 64'hF1, 4'h1); tick();
    drive(1, 64'hF2, 4'h2); tick();
    drive(1, 64'hF3, 4'h3); tick();
    rst = 1; flush = 1; drive(0, 64'h0, 4'h0); tick();
    rst = 0; flush = 0; en = 0; drive(1, 64'h77, 4'h7);
    settle(); chk("pr_ready", 64'(in_ready), 64'd0); chk("pr_occ", 64'(occ), 64'd0);
    chk("pr_data", data_out, 64'd0); edge_();
    en = 1; drive(0, 64'h0, 4'h0);
    settle(); chk("pr_occ2", 64'(occ), 64'd0); chk("pr_valid2", 64'(out_valid), 64'd0); edge_();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 99) < 5);
      en        = ($urandom_range(0, 99) < 85);
      out_ready = ($urandom_range(0, 99) < 60);
      drive($urandom_range(0, 99) < 60, {$urandom, $urandom}, 4'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
